// File: rtl/fast_decode_sched.sv
// Field-decode scheduler: latches a message template and its presence map, then hands
// fields in order to free decoder slots and counts completions until the message drains.

module fast_decode_slot #(
  parameter int OP_W = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            load,
  input  logic [OP_W-1:0] load_data,
  input  logic            op_ready,
  input  logic            dec_done,
  output logic            op_valid,
  output logic [OP_W-1:0] op_data,
  output logic            free,
  output logic            done,
  output logic            bad_done
);
  logic            op_valid_q, op_valid_d;
  logic            outst_q, outst_d;
  logic [OP_W-1:0] op_data_q, op_data_d;

  always_comb begin
    // a completing slot is reusable in the same cycle
    free       = !op_valid_q && (!outst_q || dec_done);
    done       = dec_done && outst_q;
    bad_done   = dec_done && !outst_q;
    op_valid_d = load || (op_valid_q && !op_ready);
    op_data_d  = load ? load_data : op_data_q;
    outst_d    = (outst_q && !dec_done) || (op_valid_q && op_ready);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_valid_q <= 1'b0;
      op_data_q  <= '0;
      outst_q    <= 1'b0;
    end else begin
      op_valid_q <= op_valid_d;
      op_data_q  <= op_data_d;
      outst_q    <= outst_d;
    end
  end

  assign op_valid = op_valid_q;
  assign op_data  = op_data_q;
endmodule

module fast_decode_sched #(
  parameter int BEAT_W     = 64,
  parameter int NUM_PATHS  = 4,
  parameter int NUM_DEC    = 8,
  parameter int MAX_FIELDS = 16,
  parameter int TFIELD_W   = 10,
  parameter int OP_W       = 32
) (
  input  logic                                     clk,
  input  logic                                     rstn,
  input  logic                                     msg_start,
  input  logic [$clog2(MAX_FIELDS+1)-1:0]          tmpl_len,
  input  logic [MAX_FIELDS-1:0][TFIELD_W-1:0]      tmpl,
  input  logic [NUM_PATHS-1:0]                     pmap_valid,
  input  logic [NUM_PATHS-1:0][BEAT_W-1:0]         pmap_data,
  output logic [NUM_DEC-1:0]                       op_valid,
  input  logic [NUM_DEC-1:0]                       op_ready,
  output logic [NUM_DEC-1:0][OP_W-1:0]             op_data,
  input  logic [NUM_DEC-1:0]                       dec_done,
  output logic [$clog2(MAX_FIELDS+1)-1:0]          fields_done,
  output logic                                     busy,
  output logic                                     msg_done,
  output logic                                     err
);
  localparam int LEN_W = $clog2(MAX_FIELDS+1);
  localparam int IDX_W = (MAX_FIELDS > 1) ? $clog2(MAX_FIELDS) : 1;
  localparam int BP_W  = $clog2(BEAT_W+1);
  localparam int CNT_W = $clog2(NUM_DEC+1);

  typedef enum logic [1:0] {IDLE, WAIT_PMAP, ISSUE, DRAIN} state_e;

  state_e                             state_q, state_d;
  logic [LEN_W-1:0]                   len_q, len_d;
  logic [LEN_W-1:0]                   ptr_q, ptr_d;
  logic [LEN_W-1:0]                   fields_done_q, fields_done_d;
  logic [BP_W-1:0]                    bp_q, bp_d;
  logic [MAX_FIELDS-1:0][TFIELD_W-1:0] tmpl_q, tmpl_d;
  logic [BEAT_W-1:0]                  pmap_q, pmap_d;
  logic                               msg_done_q, msg_done_d;
  logic                               err_q, err_d;

  logic [NUM_DEC-1:0]                 load, free, done, bad_done;
  logic [NUM_DEC-1:0][OP_W-1:0]       load_data;
  logic [LEN_W-1:0]                   ptr_nxt;
  logic [BP_W-1:0]                    bp_nxt;
  logic [CNT_W-1:0]                   done_cnt;
  logic [BEAT_W-1:0]                  pmap_sel;

  fast_decode_slot #(.OP_W(OP_W)) u_slot [NUM_DEC-1:0] (
    .clk       (clk),
    .rstn      (rstn),
    .load      (load),
    .load_data (load_data),
    .op_ready  (op_ready),
    .dec_done  (dec_done),
    .op_valid  (op_valid),
    .op_data   (op_data),
    .free      (free),
    .done      (done),
    .bad_done  (bad_done)
  );

  // lowest-indexed valid lane wins
  always_comb begin
    pmap_sel = '0;
    for (int l = NUM_PATHS-1; l >= 0; l--)
      if (pmap_valid[l]) pmap_sel = pmap_data[l];
  end

  // walk free slots in order, handing each the next field; the bit pointer
  // saturates at BEAT_W so a shifted-out map reads as absent
  always_comb begin
    logic [TFIELD_W-1:0] desc;
    logic [BEAT_W-1:0]   pmap_sh;
    logic                present;
    ptr_nxt   = ptr_q;
    bp_nxt    = bp_q;
    load      = '0;
    load_data = '0;
    desc      = '0;
    pmap_sh   = '0;
    present   = 1'b0;
    for (int s = 0; s < NUM_DEC; s++) begin
      if (state_q == ISSUE && free[s] && ptr_nxt < len_q) begin
        desc    = tmpl_q[ptr_nxt[IDX_W-1:0]];
        present = 1'b1;
        if (desc[TFIELD_W-1]) begin
          pmap_sh = pmap_q << bp_nxt;
          present = pmap_sh[BEAT_W-1];
          if (bp_nxt != BP_W'(BEAT_W)) bp_nxt = bp_nxt + BP_W'(1);
        end
        load[s]      = 1'b1;
        load_data[s] = OP_W'({present, ptr_nxt[IDX_W-1:0], desc});
        ptr_nxt      = ptr_nxt + LEN_W'(1);
      end
    end
  end

  always_comb begin
    done_cnt = '0;
    for (int s = 0; s < NUM_DEC; s++) done_cnt = done_cnt + CNT_W'(done[s]);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (msg_start && tmpl_len != '0) state_d = WAIT_PMAP;
      WAIT_PMAP: if (|pmap_valid) state_d = ISSUE;
      ISSUE:     if (ptr_nxt == len_q) state_d = DRAIN;
      DRAIN:     if (fields_done_q == len_q) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    len_d         = len_q;
    tmpl_d        = tmpl_q;
    ptr_d         = ptr_q;
    bp_d          = bp_q;
    pmap_d        = pmap_q;
    fields_done_d = fields_done_q + LEN_W'(done_cnt);
    msg_done_d    = 1'b0;
    err_d         = (msg_start && state_q != IDLE) || (|bad_done);
    case (state_q)
      IDLE: if (msg_start) begin
        len_d         = tmpl_len;
        tmpl_d        = tmpl;
        ptr_d         = '0;
        bp_d          = '0;
        fields_done_d = '0;
        msg_done_d    = (tmpl_len == '0);
      end
      WAIT_PMAP: if (|pmap_valid) pmap_d = pmap_sel;
      ISSUE: begin
        ptr_d = ptr_nxt;
        bp_d  = bp_nxt;
      end
      DRAIN:   msg_done_d = (fields_done_q == len_q);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      len_q         <= '0;
      tmpl_q        <= '0;
      ptr_q         <= '0;
      bp_q          <= '0;
      pmap_q        <= '0;
      fields_done_q <= '0;
      msg_done_q    <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      tmpl_q        <= tmpl_d;
      ptr_q         <= ptr_d;
      bp_q          <= bp_d;
      pmap_q        <= pmap_d;
      fields_done_q <= fields_done_d;
      msg_done_q    <= msg_done_d;
      err_q         <= err_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign fields_done = fields_done_q;
  assign msg_done    = msg_done_q;
  assign err         = err_q;
endmodule

// File: tb/tb_fast_decode_sched.sv
// Directed bench for fast_decode_sched; op word = {present[14], idx[13:10], desc[9:0]}.

module tb_fast_decode_sched;
  localparam int BEAT_W = 64, NUM_PATHS = 4, NUM_DEC = 8, MAX_FIELDS = 16;
  localparam int TFIELD_W = 10, OP_W = 32;
  localparam int LEN_W = $clog2(MAX_FIELDS+1);

  logic                                clk, rstn, msg_start;
  logic [LEN_W-1:0]                    tmpl_len;
  logic [MAX_FIELDS-1:0][TFIELD_W-1:0] tmpl;
  logic [NUM_PATHS-1:0]                pmap_valid;
  logic [NUM_PATHS-1:0][BEAT_W-1:0]    pmap_data;
  logic [NUM_DEC-1:0]                  op_valid, op_ready, dec_done;
  logic [NUM_DEC-1:0][OP_W-1:0]        op_data;
  logic [LEN_W-1:0]                    fields_done;
  logic                                busy, msg_done, err;

  int n_tests, n_fail;
  logic [MAX_FIELDS-1:0][TFIELD_W-1:0] t;

  fast_decode_sched #(
    .BEAT_W(BEAT_W), .NUM_PATHS(NUM_PATHS), .NUM_DEC(NUM_DEC),
    .MAX_FIELDS(MAX_FIELDS), .TFIELD_W(TFIELD_W), .OP_W(OP_W)
  ) dut (
    .clk(clk), .rstn(rstn), .msg_start(msg_start), .tmpl_len(tmpl_len), .tmpl(tmpl),
    .pmap_valid(pmap_valid), .pmap_data(pmap_data), .op_valid(op_valid),
    .op_ready(op_ready), .op_data(op_data), .dec_done(dec_done),
    .fields_done(fields_done), .busy(busy), .msg_done(msg_done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_msg(input int len, input logic [MAX_FIELDS-1:0][TFIELD_W-1:0] tv);
    tmpl = tv; tmpl_len = LEN_W'(len); msg_start = 1'b1;
    tick();
    msg_start = 1'b0; tmpl = '0; tmpl_len = '0;
  endtask

  task automatic give_pmap(input logic [NUM_PATHS-1:0] v);
    pmap_valid = v;
    tick();
    pmap_valid = '0;
  endtask

  // three plain fields, one cycle between acceptance and completion
  task automatic run_three(input string tag);
    logic [MAX_FIELDS-1:0][TFIELD_W-1:0] tv;
    tv = '0; tv[0] = 10'h011; tv[1] = 10'h022; tv[2] = 10'h033;
    op_ready = '1;
    start_msg(3, tv);
    chk({tag, "_busy"}, busy, 1);
    pmap_data[0] = 64'h1234;
    give_pmap(4'b0001);
    tick();
    chk({tag, "_ov"}, op_valid, 8'h07);
    chk({tag, "_op0"}, op_data[0], 64'h4011);
    chk({tag, "_op1"}, op_data[1], 64'h4422);
    chk({tag, "_op2"}, op_data[2], 64'h4833);
    tick();
    chk({tag, "_ov_drop"}, op_valid, 8'h00);
    dec_done = 8'h07; tick(); dec_done = '0;
    chk({tag, "_fd"}, fields_done, 3);
    chk({tag, "_md_early"}, msg_done, 0);
    tick();
    chk({tag, "_md"}, msg_done, 1);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_fd_hold"}, fields_done, 3);
    tick();
    chk({tag, "_md_pulse"}, msg_done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rstn = 1'b0; msg_start = 1'b0; tmpl_len = '0; tmpl = '0;
    pmap_valid = '0; pmap_data = '0; op_ready = '0; dec_done = '0;
    repeat (2) tick();
    chk("rst_busy", busy, 0);
    chk("rst_ov", op_valid, 0);
    chk("rst_op0", op_data[0], 0);
    chk("rst_fd", fields_done, 0);
    chk("rst_md", msg_done, 0);
    chk("rst_err", err, 0);
    @(negedge clk); rstn = 1'b1; tick();

    run_three("A");

    // all four fields read the map MSB-first from lane 2; lane 0 data is not valid
    t = '0;
    for (int i = 0; i < 4; i++) t[i] = TFIELD_W'(10'h200 | i);
    op_ready = '1;
    start_msg(4, t);
    pmap_data[0] = '1; pmap_data[2] = 64'hA000_0000_0000_0000;
    give_pmap(4'b0100);
    tick();
    chk("B_ov", op_valid, 8'h0F);
    chk("B_op0", op_data[0], 64'h4200);
    chk("B_op1", op_data[1], 64'h0601);
    chk("B_op2", op_data[2], 64'h4A02);
    chk("B_op3", op_data[3], 64'h0E03);
    tick();
    dec_done = 8'h0F; tick(); dec_done = '0;
    tick();
    chk("B_md", msg_done, 1);
    chk("B_fd", fields_done, 4);

    // 12 fields, only slot 0 ever completes; map from lane 1 (lane 3 also valid)
    t = '0;
    for (int i = 0; i < 8; i++) t[i] = TFIELD_W'(i);
    for (int i = 8; i < 12; i++) t[i] = TFIELD_W'(10'h200 | i);
    op_ready = '1;
    start_msg(12, t);
    pmap_data[1] = 64'hF000_0000_0000_0000; pmap_data[3] = '0;
    give_pmap(4'b1010);
    tick();
    chk("C_ov", op_valid, 8'hFF);
    chk("C_op7", op_data[7], 64'h5C07);
    tick();
    chk("C_ov_drop", op_valid, 8'h00);
    for (int k = 0; k < 4; k++) begin
      logic [63:0] exp_op [4];
      exp_op[0] = 64'h6208; exp_op[1] = 64'h6609; exp_op[2] = 64'h6A0A; exp_op[3] = 64'h6E0B;
      dec_done = 8'h01; tick(); dec_done = '0;
      chk("C_reissue_ov", op_valid, 8'h01);
      chk("C_reissue_op", op_data[0], exp_op[k]);
      chk("C_reissue_fd", fields_done, 64'(k + 1));
      tick();
      chk("C_after_hs", op_valid, 8'h00);
    end
    dec_done = 8'hFF; tick(); dec_done = '0;
    chk("C_fd", fields_done, 12);
    chk("C_md_early", msg_done, 0);
    tick();
    chk("C_md", msg_done, 1);

    // slot 3 stalls for five edges
    t = '0;
    for (int i = 0; i < 12; i++) t[i] = TFIELD_W'(i);
    op_ready = 8'hF7;
    start_msg(12, t);
    give_pmap(4'b0001);
    tick();
    chk("D_ov", op_valid, 8'hFF);
    tick();
    chk("D_ov_stall", op_valid, 8'h08);
    chk("D_op3", op_data[3], 64'h4C03);
    dec_done = 8'hF7; tick(); dec_done = '0;
    chk("D_fd7", fields_done, 7);
    chk("D_ov_refill", op_valid, 8'h1F);
    chk("D_op0", op_data[0], 64'h6008);
    chk("D_op4", op_data[4], 64'h6C0B);
    chk("D_op3_hold", op_data[3], 64'h4C03);
    tick();
    chk("D_ov_only3", op_valid, 8'h08);
    dec_done = 8'h17; tick(); dec_done = '0;
    chk("D_fd11", fields_done, 11);
    tick();
    chk("D_op3_hold2", op_data[3], 64'h4C03);
    chk("D_fd_cap", fields_done, 11);
    op_ready = '1; tick();
    chk("D_ov_acc", op_valid, 8'h00);
    chk("D_fd_cap2", fields_done, 11);
    chk("D_md_early", msg_done, 0);
    dec_done = 8'h08; tick(); dec_done = '0;
    chk("D_fd", fields_done, 12);
    tick();
    chk("D_md", msg_done, 1);

    // protocol errors mid-message
    t = '0;
    for (int i = 0; i < 10; i++) t[i] = TFIELD_W'(i);
    op_ready = '0;
    start_msg(10, t);
    give_pmap(4'b0001);
    tick();
    msg_start = 1'b1; tick(); msg_start = 1'b0;
    chk("E_err_start", err, 1);
    chk("E_busy", busy, 1);
    chk("E_ov", op_valid, 8'hFF);
    tick();
    chk("E_err_gap", err, 0);
    dec_done = 8'h01; op_ready = '1; tick(); dec_done = '0;
    chk("E_err_done", err, 1);
    chk("E_ov_hs", op_valid, 8'h00);
    chk("E_fd0", fields_done, 0);
    tick();
    chk("E_err_gap2", err, 0);
    dec_done = 8'h03; tick(); dec_done = '0;
    chk("E_ov_tail", op_valid, 8'h03);
    chk("E_op1", op_data[1], 64'h6409);
    chk("E_fd2", fields_done, 2);
    tick();
    dec_done = 8'hFF; tick(); dec_done = '0;
    chk("E_fd", fields_done, 10);
    tick();
    chk("E_md", msg_done, 1);
    chk("E_err_end", err, 0);

    // empty template completes immediately
    start_msg(0, t);
    chk("Z_md", msg_done, 1);
    chk("Z_busy", busy, 0);
    tick();
    chk("Z_md_pulse", msg_done, 0);

    // reset with five fields outstanding and three offered
    op_ready = 8'h1F;
    start_msg(10, t);
    give_pmap(4'b0001);
    tick();
    tick();
    chk("F_ov_pre", op_valid, 8'hE0);
    rstn = 1'b0;
    #1;
    chk("F_ov", op_valid, 0);
    chk("F_op5", op_data[5], 0);
    chk("F_op0", op_data[0], 0);
    chk("F_busy", busy, 0);
    chk("F_fd", fields_done, 0);
    chk("F_err", err, 0);
    tick();
    chk("F_md", msg_done, 0);
    @(negedge clk); rstn = 1'b1; tick();
    chk("F_md_after", msg_done, 0);
    run_three("F_post");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
